cache_ctrl_nway: RTL and testbench

Parametrised successor to the direct-mapped/2-way cache controller. It implements the control path for a WAYS-way, SETS-set write-back, write-allocate cache: hit service, victim selection (invalid-first, then tree pseudo-LRU), dirty write-back and line fill. It sits between the CPU-side memory port and physical memory, and drives the cache datapath's way-select, load and dirty controls. Per-set PLRU state lives inside this block.

---
 rtl/cache_ctrl_nway.sv | 231 +++++++++++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: control path for a WAYS-way, SETS-set write-back,
// write-allocate cache. It serves hits, picks a victim (invalid way
// first, otherwise tree pseudo-LRU), writes back dirty victims and
// fills lines. The per-set PLRU trees are held here.
// Optional feature macro: CACHE_CTRL_PERF_EN adds 32-bit saturating
// hit_count, miss_count and wb_count outputs.
// Handshake: mem_read/mem_write are held by the CPU until mem_resp,
// which pulses for one cycle. pmem_read/pmem_write are held until
// pmem_resp, and at most one of them is high at a time.
module cache_ctrl_nway #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [$clog2(SETS)-1:0]   set_idx,
  input  logic [WAYS-1:0]           hit_vec,
  input  logic [WAYS-1:0]           valid_vec,
  input  logic [WAYS-1:0]           dirty_vec,
  input  logic                      pmem_resp,
  output logic                      mem_resp,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic                      pmem_addr_sel,
  output logic [$clog2(WAYS)-1:0]   way_sel,
  output logic                      load_tag,
  output logic                      load_data,
  output logic                      load_valid,
  output logic                      data_in_sel,
  output logic                      set_dirty,
  output logic                      clr_dirty,
  output logic [1:0]                state_dbg
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count,
  output logic [31:0]               wb_count
`endif
);

  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAYS-2:0]  plru_q [SETS];
  logic [WAYS-2:0]  plru_d [SETS];

  logic             req;
  logic             hit;
  logic             miss_start;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic             any_inv;
  logic [WAY_W-1:0] plru_way;
  logic [WAY_W-1:0] victim_sel;
  logic             victim_dirty;
  logic [WAYS-2:0]  vic_tree;
  int               vic_node;
  logic [WAYS-2:0]  upd_tree;
  int               upd_node;

  // Reset masks the request so every output sits at its idle default.
  assign req       = (mem_read | mem_write) & ~rst;
  assign hit       = |hit_vec;
  assign state_dbg = state_q;

  // Lowest-index hitting way and lowest-index invalid way.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
      if (!valid_vec[i]) begin
        inv_way = WAY_W'(i);
        any_inv = 1'b1;
      end
    end
  end

  // Walk the PLRU tree of the indexed set; each bit points at the victim half.
  always_comb begin
    vic_tree = plru_q[set_idx];
    plru_way = '0;
    vic_node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == vic_node) plru_way[WAY_W-1-l] = vic_tree[n];
      end
      vic_node = 2 * vic_node + 1 + int'(plru_way[WAY_W-1-l]);
    end
    victim_sel   = any_inv ? inv_way : plru_way;
    victim_dirty = valid_vec[victim_sel] & dirty_vec[victim_sel];
  end

  // On a completed access, point every node on way_sel's path away from it.
  always_comb begin
    plru_d   = plru_q;
    upd_tree = plru_q[set_idx];
    upd_node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == upd_node) upd_tree[n] = ~way_sel[WAY_W-1-l];
      end
      upd_node = 2 * upd_node + 1 + int'(way_sel[WAY_W-1-l]);
    end
    if (mem_resp) plru_d[set_idx] = upd_tree;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    miss_start    = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b1;
    way_sel       = '0;
    load_tag      = 1'b0;
    load_data     = 1'b0;
    load_valid    = 1'b0;
    data_in_sel   = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            way_sel  = hit_way;
            // A simultaneous read and write is served as a write.
            if (mem_write) begin
              load_data   = 1'b1;
              data_in_sel = 1'b1;
              set_dirty   = ~dirty_vec[hit_way];
            end
          end else begin
            victim_d   = victim_sel;
            miss_start = 1'b1;
            state_d    = victim_dirty ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) begin
          clr_dirty = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = 1'b0;
        data_in_sel   = 1'b0;
        way_sel       = victim_q;
        if (pmem_resp) begin
          load_tag   = 1'b1;
          load_data  = 1'b1;
          load_valid = 1'b1;
          clr_dirty  = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latched victim and PLRU trees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      plru_q   <= plru_d;
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;
  logic        miss_seen_q, miss_seen_d;
  logic        hit_inc, wb_inc;

  // A hit that finishes a missed request is not counted as a hit.
  always_comb begin
    hit_inc     = mem_resp & ~miss_seen_q;
    wb_inc      = (state_q == WRITEBACK) & pmem_resp;
    miss_seen_d = miss_seen_q;
    if (miss_start) miss_seen_d = 1'b1;
    else if (state_q == IDLE && (mem_resp || !req)) miss_seen_d = 1'b0;
    hit_cnt_d  = hit_cnt_q  + 32'((hit_inc    && hit_cnt_q  != '1) ? 1 : 0);
    miss_cnt_d = miss_cnt_q + 32'((miss_start && miss_cnt_q != '1) ? 1 : 0);
    wb_cnt_d   = wb_cnt_q   + 32'((wb_inc     && wb_cnt_q   != '1) ? 1 : 0);
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
      miss_seen_q <= 1'b0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
      miss_seen_q <= miss_seen_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Bench for cache_ctrl_nway: a small datapath model supplies hit/valid/
// dirty vectors, requests carry their expected outcome through exp_q,
// and each mem_resp pops and checks one entry.
module tb_cache_ctrl_nway;

  localparam int WAYS = 4;
  localparam int SETS = 8;
  localparam int W    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0;
  logic       mem_write = 1'b0;
  logic [2:0] set_idx = '0;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic       pmem_resp = 1'b0;
  logic       mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic [1:0] way_sel;
  logic       load_tag, load_data, load_valid, data_in_sel, set_dirty, clr_dirty;
  logic [1:0] state_dbg;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  logic [7:0] cur_tag = '0;
  logic       dp_clr  = 1'b1;
  logic       dp_valid [SETS][WAYS];
  logic       dp_dirty [SETS][WAYS];
  logic [7:0] dp_tag   [SETS][WAYS];

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_hit = 0, n_miss = 0, n_wb = 0;

  cache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec),
    .dirty_vec(dirty_vec), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel), .load_tag(load_tag),
    .load_data(load_data), .load_valid(load_valid),
    .data_in_sel(data_in_sel), .set_dirty(set_dirty),
    .clr_dirty(clr_dirty), .state_dbg(state_dbg)
`ifdef CACHE_CTRL_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  // Clock.
  always #5 clk = ~clk;

  // Datapath model: tag/valid/dirty arrays driven by the controller.
  always @(posedge clk) begin
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (dp_clr) begin
          dp_valid[s][w] <= 1'b0;
          dp_dirty[s][w] <= 1'b0;
          dp_tag[s][w]   <= '0;
        end else if (s == int'(set_idx) && w == int'(way_sel)) begin
          if (load_valid) dp_valid[s][w] <= 1'b1;
          if (load_tag)   dp_tag[s][w]   <= cur_tag;
          if (set_dirty)  dp_dirty[s][w] <= 1'b1;
          if (clr_dirty)  dp_dirty[s][w] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w] = dp_valid[set_idx][w];
      dirty_vec[w] = dp_dirty[set_idx][w];
      hit_vec[w]   = dp_valid[set_idx][w] && (dp_tag[set_idx][w] == cur_tag);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one CPU request and serve physical memory until mem_resp.
  // lat = 0 picks a random memory latency.
  task automatic do_req(input bit rd, input bit wr, input int s, input logic [7:0] tag,
                        input int exp_way, input bit exp_miss, input bit exp_wb,
                        input bit exp_sd, input int lat);
    int c = 0, rd_cnt = 0, wr_cnt = 0, first_busy = -1, fill_c = -1, resp_c = -1;
    int load_cycles = 0, rd_lat, wr_lat;
    bit done = 0, both_high = 0, addr_bad = 0, order_bad = 0, saw_rd = 0;
    logic [1:0] fill_way = '0, got_way = '0;
    logic got_ld = 0, got_dis = 0, got_sd = 0;
    logic [W-1:0] e;
    exp_q.push_back({exp_sd, 1'b0, exp_wb, exp_miss, 2'b00, 2'(exp_way)});
    if (exp_miss) n_miss++; else n_hit++;
    if (exp_wb) n_wb++;
    rd_lat = (lat > 0) ? lat : int'($urandom_range(1, 6));
    wr_lat = (lat > 0) ? lat : int'($urandom_range(1, 6));
    @(negedge clk);
    mem_read = rd; mem_write = wr; set_idx = 3'(s); cur_tag = tag;
    while (!done && c < 200) begin
      pmem_resp = 1'b0;
      #1;
      if (pmem_read && pmem_write) both_high = 1;
      if (pmem_write) begin
        wr_cnt++;
        if (first_busy < 0) first_busy = c;
        if (!pmem_addr_sel) addr_bad = 1;
        if (saw_rd) order_bad = 1;
      end
      if (pmem_read) begin
        rd_cnt++;
        saw_rd = 1;
        if (first_busy < 0) first_busy = c;
        if (pmem_addr_sel) addr_bad = 1;
      end
      pmem_resp = (pmem_write && wr_cnt == wr_lat) || (pmem_read && rd_cnt == rd_lat);
      #1;
      if (load_tag) begin
        load_cycles++;
        fill_way = way_sel;
        fill_c   = c;
      end
      if (mem_resp) begin
        done    = 1;
        resp_c  = c;
        got_way = way_sel;
        got_ld  = load_data;
        got_dis = data_in_sel;
        got_sd  = set_dirty;
      end
      @(negedge clk);
      c++;
    end
    pmem_resp = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    e = exp_q.pop_front();
    check("resp_seen", 32'(done), 32'd1);
    check("resp_way", 32'(got_way), 32'(e[1:0]));
    check("missed", 32'(rd_cnt > 0), 32'(e[4]));
    check("wrote_back", 32'(wr_cnt > 0), 32'(e[5]));
    check("load_data", 32'(got_ld), 32'(wr));
    check("data_in_sel", 32'(got_dis), 32'(wr));
    check("set_dirty", 32'(got_sd), 32'(e[7]));
    check("rd_wr_both_high", 32'(both_high), 32'd0);
    check("addr_sel", 32'(addr_bad), 32'd0);
    check("wb_before_fill", 32'(order_bad), 32'd0);
    if (e[4]) begin
      check("fill_way", 32'(fill_way), 32'(e[1:0]));
      check("first_pmem_cycle", 32'(first_busy), 32'd1);
      check("load_pulse", 32'(load_cycles), 32'd1);
      check("resp_after_fill", 32'(resp_c), 32'(fill_c + 1));
    end else begin
      check("hit_resp_cycle", 32'(resp_c), 32'd0);
      check("no_load", 32'(load_cycles), 32'd0);
    end
  endtask

  initial begin
    int c;
    // Reset state.
    #2;
    check("rst_resp", 32'(mem_resp), 32'd0);
    check("rst_pread", 32'(pmem_read), 32'd0);
    check("rst_pwrite", 32'(pmem_write), 32'd0);
    check("rst_addr_sel", 32'(pmem_addr_sel), 32'd1);
    check("rst_way_sel", 32'(way_sel), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; dp_clr = 1'b0;
    @(negedge clk);
    check("idle_state", 32'(state_dbg), 32'd0);

    // Cold miss on set 3, fill way 0 after 5 cycles, then a plain hit.
    do_req(1, 0, 3, 8'h10, 0, 1, 0, 0, 5);
    do_req(1, 0, 3, 8'h10, 0, 0, 0, 0, 0);

    // Fill set 0 ways 0..3 in order (invalid-first).
    for (int w = 0; w < 4; w++) do_req(1, 0, 0, 8'h20 + 8'(w), w, 1, 0, 0, 0);
    // All valid and clean: PLRU picks 0, then 2 after the hit on 0.
    do_req(1, 0, 0, 8'h24, 0, 1, 0, 0, 0);
    do_req(1, 0, 0, 8'h25, 2, 1, 0, 0, 0);
    // Write hits on way 2: clean line sets dirty, dirty line does not.
    do_req(0, 1, 0, 8'h25, 2, 0, 0, 1, 0);
    do_req(1, 1, 0, 8'h25, 2, 0, 0, 0, 0);
    // Further PLRU victims.
    do_req(1, 0, 0, 8'h26, 1, 1, 0, 0, 0);
    do_req(1, 0, 0, 8'h27, 3, 1, 0, 0, 0);
    do_req(0, 1, 0, 8'h24, 0, 0, 0, 1, 0);
    // Victim way 2 is valid and dirty: write-back then fill.
    do_req(1, 0, 0, 8'h28, 2, 1, 1, 0, 0);

`ifdef CACHE_CTRL_PERF_EN
    check("hit_count", hit_count, 32'(n_hit));
    check("miss_count", miss_count, 32'(n_miss));
    check("wb_count", wb_count, 32'(n_wb));
`endif

    // Reset in the middle of a fill.
    @(negedge clk);
    mem_read = 1'b1; set_idx = 3'd5; cur_tag = 8'h50;
    c = 0;
    #1;
    while (!pmem_read && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    check("pre_rst_fill", 32'(pmem_read), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_pread", 32'(pmem_read), 32'd0);
    check("rst_async_pwrite", 32'(pmem_write), 32'd0);
    check("rst_async_state", 32'(state_dbg), 32'd0);
    check("rst_async_way", 32'(way_sel), 32'd0);
    check("rst_async_addr", 32'(pmem_addr_sel), 32'd1);
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // PLRU cleared: set 0 is full, victim is way 0, which is dirty.
    do_req(1, 0, 0, 8'h30, 0, 1, 1, 0, 0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
